adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 180 ++++++++++++++++++
 tb/tb_adder_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// Two-port request scheduler sharing one external 32-bit adder.
// Narrow ops take one adder pass; wide ops take two passes chained by carry.
module adder_sched #(
    parameter int RR_EN = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_cin,
    input  logic        req0_wide,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_cin,
    input  logic        req1_wide,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_sum,
    output logic        rsp0_cout,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_sum,
    output logic        rsp1_cout,

    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        wide_q, wide_d;
    logic [63:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        cout_q, cout_d;

    logic        grant;
    logic        accept;

    // Round-robin favours the port that did not win last; fixed mode favours port 0.
    always_comb begin
        grant = 1'b0;
        if (RR_EN != 0) begin
            if (req0_valid && req1_valid) begin
                grant = ~last_grant_q;
            end else begin
                grant = req1_valid;
            end
        end else begin
            grant = ~req0_valid && req1_valid;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        wide_d       = wide_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        add_a        = 32'h0;
        add_b        = 32'h0;
        add_cin      = 1'b0;
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    a_d          = grant ? req1_a : req0_a;
                    b_d          = grant ? req1_b : req0_b;
                    cin_d        = grant ? req1_cin : req0_cin;
                    wide_d       = grant ? req1_wide : req0_wide;
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = LO;
                end
            end
            LO: begin
                add_a   = a_q[31:0];
                add_b   = b_q[31:0];
                add_cin = cin_q;
                carry_d = add_cout;
                if (wide_q) begin
                    sum_d[31:0] = add_sum;
                    state_d     = HI;
                end else begin
                    sum_d   = {32'h0, add_sum};
                    cout_d  = add_cout;
                    state_d = RESP;
                end
            end
            HI: begin
                add_a        = a_q[63:32];
                add_b        = b_q[63:32];
                add_cin      = carry_q;
                sum_d[63:32] = add_sum;
                cout_d       = add_cout;
                state_d      = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                // Only the owner's ready releases the result.
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= 64'h0;
            b_q          <= 64'h0;
            cin_q        <= 1'b0;
            wide_q       <= 1'b0;
            sum_q        <= 64'h0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            wide_q       <= wide_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
        end
    end

    assign rsp0_sum  = sum_q;
    assign rsp0_cout = cout_q;
    assign rsp1_sum  = sum_q;
    assign rsp1_cout = cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched: one round-robin and one fixed-priority
// instance share request/response stimulus, each with its own adder model.
module tb_adder_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req0_wide, req1_cin, req1_wide;
    logic        rsp0_ready, rsp1_ready;

    logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
    logic [63:0] rr_rsp0_sum, rr_rsp1_sum;
    logic        rr_rsp0_cout, rr_rsp1_cout;
    logic [31:0] rr_add_a, rr_add_b, rr_add_sum;
    logic        rr_add_cin, rr_add_cout, rr_busy;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic [63:0] fp_rsp0_sum, fp_rsp1_sum;
    logic        fp_rsp0_cout, fp_rsp1_cout;
    logic [31:0] fp_add_a, fp_add_b, fp_add_sum;
    logic        fp_add_cin, fp_add_cout, fp_busy;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    assign {rr_add_cout, rr_add_sum} = {1'b0, rr_add_a} + {1'b0, rr_add_b} + {32'h0, rr_add_cin};
    assign {fp_add_cout, fp_add_sum} = {1'b0, fp_add_a} + {1'b0, fp_add_b} + {32'h0, fp_add_cin};

    adder_sched #(.RR_EN(1)) u_rr (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_wide(req0_wide),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_wide(req1_wide),
        .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_sum(rr_rsp0_sum), .rsp0_cout(rr_rsp0_cout),
        .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_sum(rr_rsp1_sum), .rsp1_cout(rr_rsp1_cout),
        .add_a(rr_add_a), .add_b(rr_add_b), .add_cin(rr_add_cin),
        .add_sum(rr_add_sum), .add_cout(rr_add_cout),
        .busy(rr_busy)
    );

    adder_sched #(.RR_EN(0)) u_fp (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_wide(req0_wide),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_wide(req1_wide),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_sum(fp_rsp0_sum), .rsp0_cout(fp_rsp0_cout),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_sum(fp_rsp1_sum), .rsp1_cout(fp_rsp1_cout),
        .add_a(fp_add_a), .add_b(fp_add_b), .add_cin(fp_add_cin),
        .add_sum(fp_add_sum), .add_cout(fp_add_cout),
        .busy(fp_busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_cin = 0; req0_wide = 0;
        req1_a = 0; req1_b = 0; req1_cin = 0; req1_wide = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        do_reset();
        total++;
        if (rr_busy !== 1'b0) $display("FAIL reset_busy: got %0h want 0", rr_busy);
        else passed++;
        total++;
        if ({rr_rsp1_valid, rr_rsp0_valid} !== 2'b00)
            $display("FAIL reset_rsp_valid: got %b want 00", {rr_rsp1_valid, rr_rsp0_valid});
        else passed++;
        total++;
        if ({rr_add_a, rr_add_b, rr_add_cin} !== 65'h0)
            $display("FAIL reset_add: got %0h/%0h/%0h want 0", rr_add_a, rr_add_b, rr_add_cin);
        else passed++;
        total++;
        if ({rr_rsp0_sum, rr_rsp0_cout} !== 65'h0)
            $display("FAIL reset_sum: got %0h/%0h want 0", rr_rsp0_sum, rr_rsp0_cout);
        else passed++;
        total++;
        if ({rr_req1_ready, rr_req0_ready} !== 2'b00)
            $display("FAIL reset_ready_idle: got %b want 00", {rr_req1_ready, rr_req0_ready});
        else passed++;
    endtask

    task automatic test_narrow();
        req0_valid = 1; req0_a = 64'hFFFF_FFFF; req0_b = 64'h1; req0_cin = 0; req0_wide = 0;
        #1;
        total++;
        if (rr_req0_ready !== 1'b1) $display("FAIL narrow_ready: got %0h want 1", rr_req0_ready);
        else passed++;
        step();
        req0_valid = 0;
        total++;
        if (rr_busy !== 1'b1 || rr_add_a !== 32'hFFFF_FFFF || rr_rsp0_valid !== 1'b0)
            $display("FAIL narrow_lo: got busy=%0h add_a=%0h v=%0h want 1/ffffffff/0",
                     rr_busy, rr_add_a, rr_rsp0_valid);
        else passed++;
        step();
        total++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp1_valid !== 1'b0)
            $display("FAIL narrow_latency: got v0=%0h v1=%0h want 1/0", rr_rsp0_valid, rr_rsp1_valid);
        else passed++;
        total++;
        if (rr_rsp0_sum !== 64'h0 || rr_rsp0_cout !== 1'b1 || rr_add_a !== 32'h0)
            $display("FAIL narrow_result: got sum=%0h cout=%0h add_a=%0h want 0/1/0",
                     rr_rsp0_sum, rr_rsp0_cout, rr_add_a);
        else passed++;
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        total++;
        if (rr_busy !== 1'b0) $display("FAIL narrow_done: got busy=%0h want 0", rr_busy);
        else passed++;
    endtask

    task automatic test_wide_carry();
        req1_valid = 1; req1_a = 64'h0000_0000_FFFF_FFFF; req1_b = 64'h1;
        req1_cin = 0; req1_wide = 1;
        #1;
        total++;
        if (rr_req1_ready !== 1'b1) $display("FAIL wide_ready: got %0h want 1", rr_req1_ready);
        else passed++;
        step();
        req1_valid = 0;
        rsp0_ready = 1;
        total++;
        if (rr_add_a !== 32'hFFFF_FFFF || rr_add_b !== 32'h1 || rr_add_cin !== 1'b0)
            $display("FAIL wide_lo_add: got %0h/%0h/%0h want ffffffff/1/0",
                     rr_add_a, rr_add_b, rr_add_cin);
        else passed++;
        step();
        total++;
        if (rr_add_cin !== 1'b1 || rr_add_a !== 32'h0 || rr_rsp1_valid !== 1'b0)
            $display("FAIL wide_hi_carry: got cin=%0h add_a=%0h v1=%0h want 1/0/0",
                     rr_add_cin, rr_add_a, rr_rsp1_valid);
        else passed++;
        step();
        total++;
        if (rr_rsp1_valid !== 1'b1 || rr_rsp0_valid !== 1'b0 ||
            rr_rsp1_sum !== 64'h0000_0001_0000_0000 || rr_rsp1_cout !== 1'b0)
            $display("FAIL wide_result: got v1=%0h v0=%0h sum=%0h cout=%0h want 1/0/100000000/0",
                     rr_rsp1_valid, rr_rsp0_valid, rr_rsp1_sum, rr_rsp1_cout);
        else passed++;
        step();
        total++;
        if (rr_rsp1_valid !== 1'b1 || rr_busy !== 1'b1)
            $display("FAIL nonowner_ready: got v1=%0h busy=%0h want 1/1", rr_rsp1_valid, rr_busy);
        else passed++;
        rsp0_ready = 0;
        rsp1_ready = 1;
        step();
        rsp1_ready = 0;
        total++;
        if (rr_busy !== 1'b0) $display("FAIL wide_done: got busy=%0h want 0", rr_busy);
        else passed++;
    endtask

    task automatic test_wide_overflow();
        req0_valid = 1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'h0;
        req0_cin = 1; req0_wide = 1;
        step();
        req0_valid = 0;
        step();
        step();
        total++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp0_sum !== 64'h0 || rr_rsp0_cout !== 1'b1)
            $display("FAIL wide_overflow: got v=%0h sum=%0h cout=%0h want 1/0/1",
                     rr_rsp0_valid, rr_rsp0_sum, rr_rsp0_cout);
        else passed++;
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
    endtask

    task automatic test_backpressure();
        req0_valid = 1; req0_a = 64'h5; req0_b = 64'h7; req0_cin = 0; req0_wide = 0;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_a = 64'h10; req1_b = 64'h20; req1_cin = 0; req1_wide = 0;
        #1;
        total++;
        if (rr_req1_ready !== 1'b0) $display("FAIL bp_ready_lo: got %0h want 0", rr_req1_ready);
        else passed++;
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rr_rsp0_valid !== 1'b1 || rr_rsp0_sum !== 64'hC || rr_req1_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%0h sum=%0h r1=%0h want 1/c/0",
                         i, rr_rsp0_valid, rr_rsp0_sum, rr_req1_ready);
            else passed++;
            step();
        end
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        total++;
        if (rr_busy !== 1'b0 || rr_req1_ready !== 1'b1)
            $display("FAIL bp_release: got busy=%0h r1=%0h want 0/1", rr_busy, rr_req1_ready);
        else passed++;
        req1_valid = 0;
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        req0_valid = 1; req0_a = 64'h1; req0_b = 64'h2; req0_cin = 0; req0_wide = 0;
        req1_valid = 1; req1_a = 64'h1; req1_b = 64'h2; req1_cin = 0; req1_wide = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if ({rr_req1_ready, rr_req0_ready} !== want)
                $display("FAIL rr_grant[%0d]: got %b want %b", i, {rr_req1_ready, rr_req0_ready}, want);
            else passed++;
            total++;
            if ({fp_req1_ready, fp_req0_ready} !== 2'b01)
                $display("FAIL fp_grant[%0d]: got %b want 01", i, {fp_req1_ready, fp_req0_ready});
            else passed++;
            step();
            step();
            total++;
            if ({rr_rsp1_valid, rr_rsp0_valid} !== want || rr_rsp0_sum !== 64'h3)
                $display("FAIL rr_owner[%0d]: got %b sum=%0h want %b/3",
                         i, {rr_rsp1_valid, rr_rsp0_valid}, rr_rsp0_sum, want);
            else passed++;
            step();
        end
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        step();
    endtask

    task automatic test_reset_mid();
        req1_valid = 1; req1_a = 64'h1234_0000_0000_0001; req1_b = 64'h1;
        req1_cin = 0; req1_wide = 1;
        step();
        req1_valid = 0;
        rsp1_ready = 1;
        step();
        total++;
        if (rr_busy !== 1'b1 || rr_add_a !== 32'h1234_0000)
            $display("FAIL abort_in_hi: got busy=%0h add_a=%0h want 1/12340000", rr_busy, rr_add_a);
        else passed++;
        reset = 1;
        step();
        reset = 0;
        total++;
        if (rr_busy !== 1'b0 || {rr_rsp1_valid, rr_rsp0_valid} !== 2'b00)
            $display("FAIL abort_reset: got busy=%0h v=%b want 0/00",
                     rr_busy, {rr_rsp1_valid, rr_rsp0_valid});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({rr_rsp1_valid, rr_rsp0_valid, rr_busy} !== 3'b000)
                $display("FAIL abort_no_rsp[%0d]: got %b want 000",
                         i, {rr_rsp1_valid, rr_rsp0_valid, rr_busy});
            else passed++;
        end
        rsp1_ready = 0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_narrow();
        test_wide_carry();
        test_wide_overflow();
        test_backpressure();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
